psum_accum: RTL

//   Downstream consumer of the 8-lane dot-product PE. Accumulates a stream of
//   25-bit partial sums over an input-channel group (first..last), requantizes
//   the total to int8, and buffers results in a small FIFO with valid/ready.

---
 rtl/cu33_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/psum_accum.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cu33_pkg.sv
// Shared types for the conv unit: PE product/partial-sum widths, accumulator and
// requantized output types, and the accumulator FSM encoding.
package cu33_pkg;

  localparam int unsigned MULT_W = 16;
  localparam int unsigned PSUM_W = 25;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned OUT_W  = 8;

  typedef logic signed [MULT_W-1:0] mult_t;
  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  q_t;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } accum_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A write while full is only accepted
// when a read frees a slot in the same cycle; a read while empty is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_wr, do_rd;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Accumulates PE partial sums over a first..last channel group, requantizes the
// total to a narrow signed value and buffers {total, q} in an output FIFO.
module psum_accum #(
  parameter int unsigned PSUM_W     = cu33_pkg::PSUM_W,
  parameter int unsigned ACC_W      = cu33_pkg::ACC_W,
  parameter int unsigned OUT_W      = cu33_pkg::OUT_W,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [PSUM_W-1:0] psum_in,
  input  logic [4:0]              cfg_shift,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic signed [ACC_W-1:0] out_acc,
  output logic signed [OUT_W-1:0] out_q,
  output logic [CNT_W-1:0]        fifo_cnt,
  output logic                    busy,
  input  logic                    err_clr,
  output logic                    err_proto,
  output logic                    err_sat,
  output logic                    err_drop
);

  import cu33_pkg::*;

  localparam int unsigned RES_W = ACC_W + OUT_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [ACC_W:0]   Q_MAX   = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0]   Q_MIN   = ~Q_MAX;

  accum_state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] psum_ext, sum_sat;
  logic signed [ACC_W:0]   sum_wide;
  logic                    sum_ovf;

  logic                    res_vld_q, res_vld_d;
  logic signed [ACC_W-1:0] res_q, res_d;

  logic signed [ACC_W:0]   rnd_bias, rnd_sum, rnd_shr;
  logic signed [OUT_W-1:0] q_next;
  logic                    rq_vld_q;
  logic signed [ACC_W-1:0] rq_acc_q;
  logic signed [OUT_W-1:0] rq_q_q;

  logic [RES_W-1:0]        fifo_wdata, fifo_rdata, hold_q;
  logic                    fifo_full, fifo_empty, pop;

  logic                    proto_hit, sat_hit, drop_hit;
  logic                    err_proto_q, err_sat_q, err_drop_q;

  // Accumulate one bit wider so overflow shows up as a sign mismatch.
  assign psum_ext = ACC_W'(psum_in);
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {psum_ext[ACC_W-1], psum_ext};
  assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign sum_sat  = sum_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    res_vld_d = 1'b0;
    res_d     = res_q;
    proto_hit = 1'b0;
    sat_hit   = 1'b0;
    if (in_vld) begin
      case (state_q)
        StIdle: begin
          if (!in_first) begin
            proto_hit = 1'b1;
          end
        end
        StAccum: begin
          if (in_first) begin
            proto_hit = 1'b1;
          end else begin
            acc_d   = sum_sat;
            sat_hit = sum_ovf;
            if (in_last) begin
              res_vld_d = 1'b1;
              res_d     = sum_sat;
              state_d   = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
      // A first always opens a fresh group, abandoning any partial one.
      if (in_first) begin
        acc_d = psum_ext;
        if (in_last) begin
          res_vld_d = 1'b1;
          res_d     = psum_ext;
          state_d   = StIdle;
        end else begin
          state_d = StAccum;
        end
      end
    end
  end

  // Round half up, then arithmetic shift and clip to the output range.
  always_comb begin
    rnd_bias = '0;
    if (cfg_shift != 5'd0) begin
      rnd_bias = (ACC_W+1)'(1) << (cfg_shift - 5'd1);
    end
    rnd_sum = {res_q[ACC_W-1], res_q} + rnd_bias;
    rnd_shr = rnd_sum >>> cfg_shift;
    if (rnd_shr > Q_MAX) begin
      q_next = Q_MAX[OUT_W-1:0];
    end else if (rnd_shr < Q_MIN) begin
      q_next = Q_MIN[OUT_W-1:0];
    end else begin
      q_next = rnd_shr[OUT_W-1:0];
    end
  end

  assign fifo_wdata = {rq_acc_q, rq_q_q};
  assign pop        = out_vld & out_rdy;
  assign drop_hit   = rq_vld_q & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rq_vld_q),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      res_vld_q   <= 1'b0;
      res_q       <= '0;
      rq_vld_q    <= 1'b0;
      rq_acc_q    <= '0;
      rq_q_q      <= '0;
      hold_q      <= '0;
      err_proto_q <= 1'b0;
      err_sat_q   <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      rq_vld_q  <= res_vld_q;
      if (res_vld_q) begin
        rq_acc_q <= res_q;
        rq_q_q   <= q_next;
      end
      if (pop) begin
        hold_q <= fifo_rdata;
      end
      err_proto_q <= (err_proto_q & ~err_clr) | proto_hit;
      err_sat_q   <= (err_sat_q & ~err_clr) | sat_hit;
      err_drop_q  <= (err_drop_q & ~err_clr) | drop_hit;
    end
  end

  // Once drained, the outputs keep showing the last entry consumed.
  assign out_vld            = ~fifo_empty;
  assign {out_acc, out_q}   = fifo_empty ? hold_q : fifo_rdata;
  assign busy               = (state_q == StAccum);
  assign err_proto          = err_proto_q;
  assign err_sat            = err_sat_q;
  assign err_drop           = err_drop_q;

endmodule
